instruction_queue: RTL

//   Parametrised instruction prefetch queue. It replaces the single-entry instruction register.
//   - Buffers up to DEPTH fetched instruction words in FIFO order.
//   - Presents the oldest word (head) to the control unit with opcode/operand fields split out.
//   - Sits between the memory data bus and the control unit; the fetch side pushes, decode pops.
//   - Adds flush for taken branches and a sticky overflow flag.

---
 rtl/instruction_queue.sv | 85 ++++++++
 1 files changed

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - show-ahead instruction prefetch queue with flush and sticky overflow
module instruction_queue #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int DEPTH             = 4,
    parameter int OPCODE_WIDTH      = 5
) (
    input  logic                                      clock,
    input  logic                                      iq_reset_n,
    input  logic [INSTRUCTION_WIDTH-1:0]              iq_in,
    input  logic                                      iq_wr,
    input  logic                                      iq_rd,
    input  logic                                      iq_flush,
    output logic [INSTRUCTION_WIDTH-1:0]              iq_out,
    output logic [OPCODE_WIDTH-1:0]                   iq_opcode,
    output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] iq_operand,
    output logic                                      iq_valid,
    output logic                                      iq_full,
    output logic [$clog2(DEPTH+1)-1:0]                iq_count,
    output logic                                      iq_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INSTRUCTION_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         overflow_q, overflow_d;
    logic                         push_acc;
    logic                         pop_acc;

    // Full and valid come from the registered count, so a pop at full cannot make room
    // for a push in the same cycle.
    assign iq_valid    = (count_q != '0);
    assign iq_full     = (count_q == CNT_W'(DEPTH));
    assign iq_count    = count_q;
    assign iq_overflow = overflow_q;
    assign iq_out      = iq_valid ? mem_q[rd_ptr_q] : '0;
    assign iq_opcode   = iq_out[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign iq_operand  = iq_out[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];

    always_comb begin
        push_acc   = iq_wr && !iq_full && !iq_flush;
        pop_acc    = iq_rd && iq_valid && !iq_flush;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        overflow_d = overflow_q | (iq_wr && iq_full);

        if (push_acc) begin
            mem_d[wr_ptr_q] = iq_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A taken branch drops everything, including the word being offered this cycle.
        if (iq_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!iq_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule
